dds_voice: RTL

//  Parametrised multi-waveform DDS oscillator voice for the tracker synth.
//  A phase accumulator drives arithmetically generated saw, triangle, variable-

---
 rtl/dds_voice_if.sv | 32 +++
 rtl/dds_voice.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dds_voice_if.sv
// Sequencer-side bundle for one DDS voice.
// Carries the tick/control strobes, the config words and the sample output.
interface dds_voice_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int VOL_WIDTH   = 6,
    parameter int DUTY_WIDTH  = 4
);
    logic                   tick;
    logic                   enable;
    logic                   key_on;
    logic                   cfg_load;
    logic [PHASE_WIDTH-1:0] cfg_freq;
    logic [1:0]             cfg_wave;
    logic [DUTY_WIDTH-1:0]  cfg_duty;
    logic [VOL_WIDTH-1:0]   cfg_vol;
    logic                   cfg_pending;
    logic                   wrap;
    logic [OUT_WIDTH-1:0]   wave_out;

    modport master (
        output tick, enable, key_on, cfg_load,
        output cfg_freq, cfg_wave, cfg_duty, cfg_vol,
        input  cfg_pending, wrap, wave_out
    );

    modport slave (
        input  tick, enable, key_on, cfg_load,
        input  cfg_freq, cfg_wave, cfg_duty, cfg_vol,
        output cfg_pending, wrap, wave_out
    );
endinterface

// File: rtl/dds_voice.sv
// Multi-waveform DDS voice: phase accumulator, saw/tri/pulse/noise, volume.
// Config is double-buffered and lands on phase wrap so edits never click.
module dds_voice #(
    parameter int PHASE_WIDTH  = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int VOL_WIDTH    = 6,
    parameter int DUTY_WIDTH   = 4,
    parameter int OUT_UNSIGNED = 1
) (
    input logic       clk,
    input logic       rst_active_high,
    dds_voice_if.slave vif
);
    localparam int PW = PHASE_WIDTH;
    localparam int N  = OUT_WIDTH;
    localparam int V  = VOL_WIDTH;
    localparam int D  = DUTY_WIDTH;

    localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] OFFS = (OUT_UNSIGNED != 0) ? HALF : '0;

    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] freq_sh_q, freq_act_q;
    logic [1:0]    wave_sh_q, wave_act_q;
    logic [D-1:0]  duty_sh_q, duty_act_q;
    logic [V-1:0]  vol_sh_q, vol_act_q;
    logic          pending_q;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          wrap_q;
    logic [N-1:0]  w_q, w_d;
    logic [V-1:0]  volp_q;
    logic [N-1:0]  out_q, out_d;

    logic [PW:0]   sum;
    logic          carry;
    logic          run;
    logic          apply;
    logic          lfsr_step;

    always_comb begin
        sum   = {1'b0, phase_q} + {1'b0, freq_act_q};
        carry = sum[PW];
        run   = vif.tick && vif.enable;
        apply = pending_q &&
                (!vif.enable || (vif.tick && (carry || vif.key_on)));
        // Noise clocks whenever the top nibble of phase moves: 16 steps/period
        lfsr_step = run && !vif.key_on &&
                    (sum[PW:PW-4] != {1'b0, phase_q[PW-1:PW-4]});
        phase_d = phase_q;
        if (vif.tick && vif.key_on) begin
            phase_d = '0;
        end else if (run) begin
            phase_d = sum[PW-1:0];
        end
        lfsr_d = lfsr_q;
        if (lfsr_step) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                      lfsr_q[15:1]};
        end
    end

    logic [N-1:0] noise_w;

    generate
        if (N > 16) begin : g_noise_ext
            assign noise_w = {{(N-16){lfsr_q[15]}}, lfsr_q};
        end else begin : g_noise_trunc
            assign noise_w = lfsr_q[N-1:0];
        end
    endgenerate

    logic [N-1:0] p;
    logic [N-1:0] p2;
    logic [N-1:0] tri_u;

    always_comb begin
        p     = phase_q[PW-1 -: N];
        p2    = {p[N-2:0], 1'b0};
        tri_u = p[N-1] ? ~p2 : p2;
        w_d   = '0;
        unique case (wave_act_q)
            2'd0:    w_d = p ^ HALF;
            2'd1:    w_d = tri_u ^ HALF;
            2'd2:    w_d = (p[N-1 -: D] < duty_act_q) ? ~HALF : HALF;
            default: w_d = noise_w;
        endcase
    end

    logic signed [N+V:0] prod;

    always_comb begin
        prod  = $signed(w_q) * $signed({1'b0, volp_q});
        out_d = N'(prod >>> V) + OFFS;
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            phase_q    <= '0;
            freq_sh_q  <= '0;
            wave_sh_q  <= '0;
            duty_sh_q  <= '0;
            vol_sh_q   <= '0;
            freq_act_q <= '0;
            wave_act_q <= '0;
            duty_act_q <= '0;
            vol_act_q  <= '0;
            pending_q  <= 1'b0;
            lfsr_q     <= 16'hACE1;
            wrap_q     <= 1'b0;
            w_q        <= '0;
            volp_q     <= '0;
            out_q      <= OFFS;
        end else begin
            if (vif.cfg_load) begin
                freq_sh_q <= vif.cfg_freq;
                wave_sh_q <= vif.cfg_wave;
                duty_sh_q <= vif.cfg_duty;
                vol_sh_q  <= vif.cfg_vol;
            end
            pending_q <= vif.cfg_load || (pending_q && !apply);
            if (apply) begin
                freq_act_q <= freq_sh_q;
                wave_act_q <= wave_sh_q;
                duty_act_q <= duty_sh_q;
                vol_act_q  <= vol_sh_q;
            end
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
            wrap_q  <= run && carry && !vif.key_on;
            // Volume travels with its sample so a change lands 2 ticks later
            if (vif.tick) begin
                w_q    <= w_d;
                volp_q <= vol_act_q;
                out_q  <= out_d;
            end
        end
    end

    assign vif.cfg_pending = pending_q;
    assign vif.wrap        = wrap_q;
    assign vif.wave_out    = out_q;
endmodule
